bcd_to_bin: RTL and testbench
=============================

// Module: bcd_to_bin
// PURPOSE
//  Multi-cycle packed-BCD to binary decoder; inverse of the decimal adjust done by the
//  CPU misc ALU (DAA produces packed BCD, this block recovers the binary value).
//  Sits beside the CPU datapath for debug/peripheral use (e.g. converting BCD score or
//  timer bytes held in A); valid/ready on both sides; reverse double-dabble, one bit/cycle.
// PARAMETERS
//  DIGITS  2  number of packed BCD digits on input; N = 4*DIGITS = data width and shift count
// PORTS
//  i_Clk    in   1    system clock, all state on rising edge
//  i_Rst_n  in   1    asynchronous, active-low reset
//  i_Valid  in   1    i_BCD holds a request
//  o_Ready  out  1    block can accept a request (high only in IDLE)
//  i_BCD    in   N    packed BCD, digit 0 in [3:0]
//  o_Valid  out  1    o_Bin/o_Err hold a result
//  i_Ready  in   1    consumer accepts result
//  o_Bin    out  N    binary value (upper unused bits zero, e.g. 99 -> 8'h63)
//  o_Err    out  1    input had a nibble > 9 (only with BCD_TO_BIN_ERR_CHECK_EN)
// BEHAVIOUR
//  - Reset (async, i_Rst_n=0): state=IDLE, o_Ready=1, o_Valid=0, o_Bin=0, o_Err=0,
//    counter=0, work register=0. Reset mid-conversion aborts; no result produced.
//  - Work register W of 2N bits = {bcd[N-1:0], bin[N-1:0]}.
//  - States: IDLE -> SHIFT -> DONE -> IDLE.
//  - IDLE: o_Ready=1. On edge with i_Valid&&o_Ready: W <= {i_BCD, N'b0}, cnt <= 0,
//    err latch <= (any i_BCD nibble > 9), go SHIFT. i_BCD sampled only at this edge.
//  - SHIFT: o_Ready=0. Each edge: W' = W >> 1 (zero into MSB); then every BCD nibble of
//    W' that is >= 8 has 3 subtracted (per nibble, 4-bit, no borrow between nibbles);
//    store; cnt++. After N-th step (cnt==N-1) go DONE, o_Bin <= resulting bin half.
//  - Latency: o_Valid rises exactly N cycles after the accepting edge (8 for DIGITS=2).
//  - DONE: o_Valid=1, o_Bin/o_Err stable while o_Valid && !i_Ready (back-pressure
//    holds indefinitely). On edge with i_Ready: o_Valid<=0, go IDLE, o_Ready<=1.
//  - No overlap: new request not accepted in SHIFT or DONE; next accept earliest the
//    cycle after result handshake. Throughput: one conversion per N+2 cycles minimum.
//  - i_Valid while o_Ready=0 is ignored; requester must hold until accepted.
//  - i_Ready while o_Valid=0 has no effect.
//  - Arithmetic wraps within 4-bit nibbles; for valid BCD input no nibble underflows.
//  - Max output 10^DIGITS-1 always fits in N bits.
// CONFIGURATION
//  - BCD_TO_BIN_ERR_CHECK_EN defined: err latch computed at accept; in DONE o_Err=err;
//    if err=1, o_Bin forced to 0 (conversion still runs full N cycles, latency unchanged).
//  - Not defined: no nibble check logic; o_Err tied 0; invalid input gives whatever
//    the shift/correct algorithm yields (unspecified but deterministic).
// TESTING
//  1. DIGITS=2, i_BCD=8'h99, i_Ready=1 -> o_Valid after 8 cycles, o_Bin=8'h63, o_Err=0.
//  2. i_BCD=8'h42 then 8'h00 back-to-back requests -> 8'h2A, then 8'h00; second
//     accepted only after first handshake; o_Ready low throughout SHIFT/DONE.
//  3. i_BCD=8'h27, i_Ready=0 for 5 cycles after o_Valid -> o_Bin=8'h1B held stable,
//     o_Valid stays 1, o_Ready stays 0; released on i_Ready=1.
//  4. Assert i_Rst_n=0 at SHIFT cycle 3 of 8'h55 -> outputs at reset values immediately;
//     no o_Valid pulse; next request 8'h10 -> 8'h0A.
//  5. With BCD_TO_BIN_ERR_CHECK_EN, i_BCD=8'h1A -> o_Err=1, o_Bin=0, latency 8;
//     without macro -> o_Err=0.
//  6. DIGITS=4, i_BCD=16'h9999 -> o_Bin=16'h270F after 16 cycles; 16'h0001 -> 16'h0001.

Source files
------------

// File: rtl/bcd_to_bin.sv
// Multi-cycle packed-BCD to binary decoder (reverse double-dabble, one bit per clock).
// Optional nibble range check is enabled by defining BCD_TO_BIN_ERR_CHECK_EN.
//
//  state   | meaning
//  --------+-----------------------------------------------------------
//  S_IDLE  | waiting for a request, o_Ready high
//  S_SHIFT | N shift/correct steps on the work register
//  S_DONE  | result presented on o_Bin/o_Err, waiting for i_Ready
module bcd_to_bin #(
    parameter int DIGITS = 2
) (
    input  logic                  i_Clk,
    input  logic                  i_Rst_n,
    input  logic                  i_Valid,
    output logic                  o_Ready,
    input  logic [4*DIGITS-1:0]   i_BCD,
    output logic                  o_Valid,
    input  logic                  i_Ready,
    output logic [4*DIGITS-1:0]   o_Bin,
    output logic                  o_Err
);
    localparam int N  = 4 * DIGITS;
    localparam int CW = $clog2(N) + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [2*N-1:0]   r_work;
    logic [2*N-1:0]   w_shifted;
    logic [2*N-1:0]   w_work_next;
    logic [CW-1:0]    r_cnt;
    logic [N-1:0]     r_bin;
    logic             w_last;
    logic             w_err_in;
    logic             r_err;

    assign w_last = (r_cnt == CW'(N - 1));

    // Shift right, then pull every BCD nibble that landed at >= 8 back by 3.
    always_comb begin
        w_shifted   = r_work >> 1;
        w_work_next = w_shifted;
        for (int d = 0; d < DIGITS; d++) begin
            if (w_shifted[N + 4*d + 3 -: 4] >= 4'd8) begin
                w_work_next[N + 4*d + 3 -: 4] = w_shifted[N + 4*d + 3 -: 4] - 4'd3;
            end
        end
    end

`ifdef BCD_TO_BIN_ERR_CHECK_EN
    always_comb begin
        w_err_in = 1'b0;
        for (int d = 0; d < DIGITS; d++) begin
            if (i_BCD[4*d + 3 -: 4] > 4'd9) begin
                w_err_in = 1'b1;
            end
        end
    end
`else
    assign w_err_in = 1'b0;
`endif

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (i_Valid) w_state_next = S_SHIFT;
            S_SHIFT: if (w_last)  w_state_next = S_DONE;
            S_DONE:  if (i_Ready) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_work <= '0;
            r_cnt  <= '0;
            r_bin  <= '0;
            r_err  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_Valid) begin
                        r_work <= {i_BCD, {N{1'b0}}};
                        r_cnt  <= '0;
                        r_err  <= w_err_in;
                    end
                end
                S_SHIFT: begin
                    r_work <= w_work_next;
                    r_cnt  <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_bin <= r_err ? '0 : w_work_next[N-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_Ready = (r_state == S_IDLE);
    assign o_Valid = (r_state == S_DONE);
    assign o_Bin   = r_bin;
`ifdef BCD_TO_BIN_ERR_CHECK_EN
    assign o_Err   = o_Valid & r_err;
`else
    assign o_Err   = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_to_bin.sv
// Self-checking bench for bcd_to_bin (DIGITS=2): vector table, latency,
// back-pressure, ignored requests and reset abort, with an expected-result queue.
module tb_bcd_to_bin;
    logic       clk;
    logic       rst_n;
    logic       i_Valid;
    logic       o_Ready;
    logic [7:0] i_BCD;
    logic       o_Valid;
    logic       i_Ready;
    logic [7:0] o_Bin;
    logic       o_Err;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [7:0] bcd;
        logic [7:0] exp_bin;
        logic       exp_err;
        logic       chk_bin;
        int         hold;
    } vec_t;

    typedef struct {
        logic [7:0] bin;
        logic       err;
        logic       chk_bin;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    bcd_to_bin #(.DIGITS(2)) dut (
        .i_Clk   (clk),
        .i_Rst_n (rst_n),
        .i_Valid (i_Valid),
        .o_Ready (o_Ready),
        .i_BCD   (i_BCD),
        .o_Valid (o_Valid),
        .i_Ready (i_Ready),
        .o_Bin   (o_Bin),
        .o_Err   (o_Err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] bcd_model(input logic [7:0] b);
        return 8'(b[7:4] * 10 + b[3:0]);
    endfunction

    task automatic run_one(input vec_t v);
        int   cyc;
        logic ready_bad;
        logic [7:0] held_bin;
        exp_t e;
        @(negedge clk);
        i_BCD   = v.bcd;
        i_Valid = 1'b1;
        i_Ready = (v.hold == 0);
        cyc = 0;
        while (!o_Ready && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        chk("accept_ready", {31'd0, o_Ready}, 32'd1);
        @(posedge clk);
        e.bin = v.exp_bin; e.err = v.exp_err; e.chk_bin = v.chk_bin;
        sb.push_back(e);
        #1;
        i_Valid = 1'b0;
        i_BCD   = 8'($urandom);
        cyc = 0;
        ready_bad = 1'b0;
        while (cyc < 40) begin
            @(posedge clk);
            cyc++;
            #1;
            if (o_Ready) ready_bad = 1'b1;
            if (o_Valid) break;
        end
        chk("latency", cyc, 8);
        chk("ready_low_busy", {31'd0, ready_bad}, 32'd0);
        held_bin = o_Bin;
        for (int k = 0; k < v.hold; k++) begin
            i_Valid = 1'b1;
            i_BCD   = 8'h77;
            @(posedge clk);
            #1;
            chk("hold_valid", {31'd0, o_Valid}, 32'd1);
            chk("hold_ready", {31'd0, o_Ready}, 32'd0);
            chk("hold_bin", {24'd0, o_Bin}, {24'd0, held_bin});
        end
        i_Valid = 1'b0;
        i_Ready = 1'b1;
        if (sb.size() == 0) begin
            chk("sb_nonempty", 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            if (e.chk_bin) chk($sformatf("bin_%02h", v.bcd), {24'd0, o_Bin}, {24'd0, e.bin});
            chk($sformatf("err_%02h", v.bcd), {31'd0, o_Err}, {31'd0, e.err});
        end
        @(posedge clk);
        #1;
        chk("post_hs_valid", {31'd0, o_Valid}, 32'd0);
        chk("post_hs_ready", {31'd0, o_Ready}, 32'd1);
    endtask

    function automatic vec_t mk(input logic [7:0] b, input logic [7:0] exp, input int hold);
        vec_t v;
        v.bcd = b; v.exp_bin = exp; v.exp_err = 1'b0; v.chk_bin = 1'b1; v.hold = hold;
        return v;
    endfunction

    initial begin
        vec_t v;
        int   cyc;
        logic saw_valid;
        rst_n   = 1'b0;
        i_Valid = 1'b0;
        i_Ready = 1'b0;
        i_BCD   = 8'h00;

        vecs.push_back(mk(8'h99, 8'h63, 0));
        vecs.push_back(mk(8'h42, 8'h2A, 0));
        vecs.push_back(mk(8'h00, 8'h00, 0));
        vecs.push_back(mk(8'h27, 8'h1B, 5));
        vecs.push_back(mk(8'h55, 8'h37, 0));
        vecs.push_back(mk(8'h01, 8'h01, 1));
        vecs.push_back(mk(8'h80, 8'h50, 0));
        vecs.push_back(mk(8'h19, 8'h13, 0));
        vecs.push_back(mk(8'h90, 8'h5A, 2));
        v = mk(8'h1A, 8'h00, 0);
`ifdef BCD_TO_BIN_ERR_CHECK_EN
        v.exp_err = 1'b1;
`else
        v.chk_bin = 1'b0;
`endif
        vecs.push_back(v);
        for (int i = 0; i < 6; i++) begin
            logic [7:0] b;
            b = {4'($urandom_range(9)), 4'($urandom_range(9))};
            vecs.push_back(mk(b, bcd_model(b), int'($urandom_range(2))));
        end

        #12;
        chk("rst_ready", {31'd0, o_Ready}, 32'd1);
        chk("rst_valid", {31'd0, o_Valid}, 32'd0);
        chk("rst_bin", {24'd0, o_Bin}, 32'd0);
        chk("rst_err", {31'd0, o_Err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) run_one(vecs[i]);

        // Reset in the middle of a conversion of 0x55.
        @(negedge clk);
        i_BCD = 8'h55; i_Valid = 1'b1; i_Ready = 1'b1;
        @(posedge clk);
        #1;
        i_Valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_ready", {31'd0, o_Ready}, 32'd1);
        chk("abort_valid", {31'd0, o_Valid}, 32'd0);
        chk("abort_bin", {24'd0, o_Bin}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        saw_valid = 1'b0;
        for (cyc = 0; cyc < 12; cyc++) begin
            @(posedge clk);
            #1;
            if (o_Valid) saw_valid = 1'b1;
        end
        chk("abort_no_valid", {31'd0, saw_valid}, 32'd0);
        run_one(mk(8'h10, 8'h0A, 0));

        chk("sb_empty", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
